pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Program-counter owner for the multicycle MIPS datapath and consumer of the branch comparator's taken/not-taken result. Holds the PC, advances it sequentially on control request, and redirects it for conditional branches (two-step evaluate/commit sequence), J/JAL and JR. It sits between the main control FSM, the branch comparator and the instruction-memory address port.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `pc_step` input 1: control requests sequential advance (PC+4) at end of instruction.
- `br_req` input 1: current instruction is a conditional branch; start evaluation.
- `br_taken` input 1: comparator result; valid only while `busy`=1 in BR_EVAL.
- `jmp_req` input 2: 00 none, 01 absolute (J/JAL), 10 register (JR/JALR), 11 reserved (treated as 00).
- `imm16` input 16: branch offset in words, signed.
- `instr_index` input 26: J-type target field.
- `jr_addr` input 32: register jump target.
- `pc` output 32: current PC.
- `pc_plus4` output 32: combinational `pc`+4.
- `link_addr` output 32: `pc_plus4` captured when a jump is accepted.
- `busy` output 1: high in BR_EVAL; new requests ignored.
- `redirect` output 1: one-cycle pulse in the cycle after PC is loaded with a non-sequential target.
- `misalign_err` output 1: sticky JR misalignment flag (see Configuration).

## Operation
- States: RUN, BR_EVAL.
- RUN, request priority br_req > jmp_req > pc_step; only the highest is acted on at the edge.
  - br_req: `tgt_q` <= `pc_plus4` + (sign_extend(imm16) << 2), mod 2^32; go to BR_EVAL; PC unchanged.
  - jmp_req=01: `pc` <= {`pc_plus4`[31:28], instr_index, 2'b00}; `link_addr` <= `pc_plus4`; `redirect` pulses.
  - jmp_req=10: `pc` <= jr_addr, subject to the alignment rule; `link_addr` <= `pc_plus4`; `redirect` pulses.
  - pc_step only: `pc` <= `pc_plus4`; no redirect.
  - Nothing asserted: hold.
- BR_EVAL: at the next edge, sample `br_taken`.
  - br_taken=1: `pc` <= `tgt_q`; `redirect` pulses.
  - br_taken=0: `pc` <= `pc_plus4`.
  - Both cases return to RUN. `pc_step`, `jmp_req` and `br_req` are ignored in BR_EVAL.
- All additions are 32-bit and wrap modulo 2^32. `pc` = 32'hFFFF_FFFC + 4 gives 0; a negative offset below 0 wraps.

## Timing
- Reset (async, `rst_n`=0): `pc`=RESET_PC, state RUN, `tgt_q`=0, `link_addr`=0, `busy`=0, `redirect`=0, `misalign_err`=0.
- Reset asserted in BR_EVAL aborts the branch: the PC does not take `tgt_q`.
- Sequential step and jumps: 1 edge latency.
- Conditional branch: 2 edges (accept, commit). `busy`=1 for exactly one cycle.
- `br_taken` is only required to be stable at the BR_EVAL rising edge. The comparator updates it on the preceding falling edge.
- `redirect` is registered: high for exactly the one cycle after the redirecting edge.
- Branches not taken still consume both edges.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - JR with jr_addr[1:0] != 0 sets `misalign_err` (sticky until reset).
  - `pc` <= `pc_plus4` instead of the target; no `redirect`; `link_addr` is still captured.
- `PC_ALIGN_CHECK_EN` undefined:
  - JR loads {jr_addr[31:2], 2'b00}; `redirect` pulses.
  - `misalign_err` is tied 0.

## Test plan
- Reset then pc_step for 3 cycles -> `pc` 0x3000, 0x3004, 0x3008, 0x300C; `redirect` stays 0.
- At pc=0x3010: br_req with imm16=0xFFFC, br_taken=1 in BR_EVAL -> `busy` high 1 cycle, `pc`=0x3004, `redirect` pulse; the same with br_taken=0 -> `pc`=0x3014.
- At pc=0x3020: jmp_req=01 with instr_index=0x0000C10 -> `pc`=0x0000_3040, `link_addr`=0x3024; br_req and jmp_req together -> branch path wins.
- JR with jr_addr=0x0000_3102:
  - With the macro: `misalign_err`=1, `pc` advances +4.
  - Without the macro: `pc`=0x3100, `redirect` pulse.
- `rst_n` low mid-BR_EVAL with br_taken=1 -> `pc`=RESET_PC, `busy`=0, no redirect. pc=0xFFFF_FFFC plus pc_step -> `pc`=0.

Source files
------------

// File: rtl/pc_redirect_unit_if.sv
// Request/response bundle between the control FSM, branch comparator,
// instruction-memory address port and the PC redirect unit.
interface pc_redirect_unit_if;
   logic        pc_step;
   logic        br_req;
   logic        br_taken;
   logic [1:0]  jmp_req;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] jr_addr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] link_addr;
   logic        busy;
   logic        redirect;
   logic        misalign_err;

   // Control/comparator side: drives requests, observes the PC
   modport master (
      output pc_step, br_req, br_taken, jmp_req, imm16, instr_index, jr_addr,
      input  pc, pc_plus4, link_addr, busy, redirect, misalign_err
   );

   // PC owner side
   modport slave (
      input  pc_step, br_req, br_taken, jmp_req, imm16, instr_index, jr_addr,
      output pc, pc_plus4, link_addr, busy, redirect, misalign_err
   );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the multicycle MIPS PC. Sequential advance,
// two-step conditional branch (evaluate, commit), J/JAL and JR/JALR.
// Optional build macro PC_ALIGN_CHECK_EN: misaligned JR targets are
// rejected (PC advances by 4) and flagged in sticky misalign_err.
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input logic           clk,
   input logic           rst_n,
   pc_redirect_unit_if.slave bus
);

   localparam int unsigned PC_W = 32;

   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_BR_EVAL = 1'b1;

   localparam logic [1:0] JMP_ABS = 2'b01;
   localparam logic [1:0] JMP_REG = 2'b10;

   logic [0:0]      r_state;
   logic [0:0]      w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_nxt;
   logic [PC_W-1:0] r_tgt_q;
   logic [PC_W-1:0] w_tgt_nxt;
   logic [PC_W-1:0] r_link;
   logic [PC_W-1:0] w_link_nxt;
   logic            r_redirect;
   logic            w_redirect_nxt;
   logic            r_misalign;
   logic            w_misalign_nxt;

   logic [PC_W-1:0] w_pc_plus4;
   logic [PC_W-1:0] w_br_off;
   logic [PC_W-1:0] w_br_tgt;
   logic [PC_W-1:0] w_j_tgt;
   logic [PC_W-1:0] w_jr_tgt;
   logic            w_jr_bad;

   // Target arithmetic, all modulo 2^32
   assign w_pc_plus4 = r_pc + PC_W'(4);
   assign w_br_off   = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
   assign w_br_tgt   = w_pc_plus4 + w_br_off;
   assign w_j_tgt    = {w_pc_plus4[31:28], bus.instr_index, 2'b00};
   assign w_jr_tgt   = bus.jr_addr & 32'hFFFF_FFFC;

`ifdef PC_ALIGN_CHECK_EN
   // Low address bits set means the register target is not word aligned
   assign w_jr_bad = |bus.jr_addr[1:0];
`else
   // Without the check the low bits are simply dropped
   assign w_jr_bad = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-datapath decode; branch wins over jump over step
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_tgt_nxt      = r_tgt_q;
      w_link_nxt     = r_link;
      w_redirect_nxt = 1'b0;
      w_misalign_nxt = r_misalign;
      case (r_state)
         ST_RUN: begin
            if (bus.br_req) begin
               w_tgt_nxt   = w_br_tgt;
               w_state_nxt = ST_BR_EVAL;
            end else if (bus.jmp_req == JMP_ABS) begin
               w_pc_nxt       = w_j_tgt;
               w_link_nxt     = w_pc_plus4;
               w_redirect_nxt = 1'b1;
            end else if (bus.jmp_req == JMP_REG) begin
               w_link_nxt = w_pc_plus4;
               if (w_jr_bad) begin
                  w_pc_nxt       = w_pc_plus4;
                  w_misalign_nxt = 1'b1;
               end else begin
                  w_pc_nxt       = w_jr_tgt;
                  w_redirect_nxt = 1'b1;
               end
            end else if (bus.pc_step) begin
               w_pc_nxt = w_pc_plus4;
            end
         end
         ST_BR_EVAL: begin
            w_state_nxt = ST_RUN;
            if (bus.br_taken) begin
               w_pc_nxt       = r_tgt_q;
               w_redirect_nxt = 1'b1;
            end else begin
               w_pc_nxt = w_pc_plus4;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_tgt_q    <= '0;
         r_link     <= '0;
         r_redirect <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_pc       <= w_pc_nxt;
         r_tgt_q    <= w_tgt_nxt;
         r_link     <= w_link_nxt;
         r_redirect <= w_redirect_nxt;
         r_misalign <= w_misalign_nxt;
      end
   end

   assign bus.pc           = r_pc;
   assign bus.pc_plus4     = w_pc_plus4;
   assign bus.link_addr    = r_link;
   assign bus.busy         = (r_state == ST_BR_EVAL);
   assign bus.redirect     = r_redirect;
   assign bus.misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed-vector bench for pc_redirect_unit with hand-computed expectations.
module tb_pc_redirect_unit;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   pc_redirect_unit_if bus ();

   pc_redirect_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pc_step     = 1'b0;
      bus.br_req      = 1'b0;
      bus.jmp_req     = 2'b00;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      idle();
      bus.br_taken    = 1'b0;
      bus.imm16       = 16'h0000;
      bus.instr_index = 26'h0;
      bus.jr_addr     = 32'h0;
      #12;
      check_eq("rst_pc",       bus.pc, 32'h0000_3000);
      check_eq("rst_busy",     32'(bus.busy), 32'h0);
      check_eq("rst_redirect", 32'(bus.redirect), 32'h0);
      check_eq("rst_link",     bus.link_addr, 32'h0);
      check_eq("rst_misalign", 32'(bus.misalign_err), 32'h0);
      check_eq("rst_plus4",    bus.pc_plus4, 32'h0000_3004);
      rst_n = 1'b1;

      // Sequential stepping
      bus.pc_step = 1'b1;
      step(); check_eq("step1", bus.pc, 32'h0000_3004);
      check_eq("step1_red", 32'(bus.redirect), 32'h0);
      step(); check_eq("step2", bus.pc, 32'h0000_3008);
      step(); check_eq("step3", bus.pc, 32'h0000_300C);
      check_eq("step3_red", 32'(bus.redirect), 32'h0);
      step(); check_eq("step4", bus.pc, 32'h0000_3010);
      idle();

      // Taken branch, offset -4 words: 0x3014 - 16 = 0x3004
      bus.br_req = 1'b1; bus.imm16 = 16'hFFFC;
      step(); check_eq("bt_busy", 32'(bus.busy), 32'h1);
      check_eq("bt_pc_hold", bus.pc, 32'h0000_3010);
      idle(); bus.br_taken = 1'b1;
      step(); check_eq("bt_pc", bus.pc, 32'h0000_3004);
      check_eq("bt_red", 32'(bus.redirect), 32'h1);
      check_eq("bt_busy_off", 32'(bus.busy), 32'h0);
      bus.br_taken = 1'b0;
      step(); check_eq("bt_red_off", 32'(bus.redirect), 32'h0);
      check_eq("bt_hold", bus.pc, 32'h0000_3004);

      // Back to 0x3010, not-taken branch; requests in BR_EVAL are ignored
      bus.pc_step = 1'b1;
      step(); step(); step();
      check_eq("nt_start", bus.pc, 32'h0000_3010);
      idle(); bus.br_req = 1'b1;
      step(); check_eq("nt_busy", 32'(bus.busy), 32'h1);
      bus.br_req = 1'b1; bus.jmp_req = 2'b01; bus.instr_index = 26'h0000_111;
      bus.br_taken = 1'b0;
      step(); check_eq("nt_pc", bus.pc, 32'h0000_3014);
      check_eq("nt_red", 32'(bus.redirect), 32'h0);
      check_eq("nt_busy_off", 32'(bus.busy), 32'h0);
      check_eq("nt_link", bus.link_addr, 32'h0);

      // Advance to 0x3020 and take J
      idle(); bus.pc_step = 1'b1;
      step(); step(); step();
      check_eq("j_start", bus.pc, 32'h0000_3020);
      idle(); bus.jmp_req = 2'b01; bus.instr_index = 26'h0000C10;
      step(); check_eq("j_pc", bus.pc, 32'h0000_3040);
      check_eq("j_link", bus.link_addr, 32'h0000_3024);
      check_eq("j_red", 32'(bus.redirect), 32'h1);

      // Branch and jump together: branch wins, target 0x3044 + 16
      bus.br_req = 1'b1; bus.jmp_req = 2'b01; bus.instr_index = 26'h0000_200;
      bus.imm16 = 16'h0004;
      step(); check_eq("bj_busy", 32'(bus.busy), 32'h1);
      check_eq("bj_pc_hold", bus.pc, 32'h0000_3040);
      check_eq("bj_link_hold", bus.link_addr, 32'h0000_3024);
      check_eq("bj_red", 32'(bus.redirect), 32'h0);
      idle(); bus.br_taken = 1'b1;
      step(); check_eq("bj_pc", bus.pc, 32'h0000_3054);
      check_eq("bj_red2", 32'(bus.redirect), 32'h1);
      bus.br_taken = 1'b0;

      // JR to a misaligned register target
      bus.jmp_req = 2'b10; bus.jr_addr = 32'h0000_3102;
      step();
      check_eq("jr_link", bus.link_addr, 32'h0000_3058);
`ifdef PC_ALIGN_CHECK_EN
      check_eq("jr_pc", bus.pc, 32'h0000_3058);
      check_eq("jr_red", 32'(bus.redirect), 32'h0);
      check_eq("jr_mis", 32'(bus.misalign_err), 32'h1);
      idle();
      step(); check_eq("jr_mis_sticky", 32'(bus.misalign_err), 32'h1);
`else
      check_eq("jr_pc", bus.pc, 32'h0000_3100);
      check_eq("jr_red", 32'(bus.redirect), 32'h1);
      check_eq("jr_mis", 32'(bus.misalign_err), 32'h0);
      idle();
      step(); check_eq("jr_red_off", 32'(bus.redirect), 32'h0);
`endif

      // Reset in BR_EVAL aborts a taken branch
      bus.br_req = 1'b1; bus.imm16 = 16'h0010;
      step(); check_eq("ra_busy", 32'(bus.busy), 32'h1);
      idle(); bus.br_taken = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_eq("ra_pc", bus.pc, 32'h0000_3000);
      check_eq("ra_busy_off", 32'(bus.busy), 32'h0);
      step();
      check_eq("ra_pc_held", bus.pc, 32'h0000_3000);
      check_eq("ra_red", 32'(bus.redirect), 32'h0);
      check_eq("ra_mis", 32'(bus.misalign_err), 32'h0);
      rst_n = 1'b1;
      bus.br_taken = 1'b0;
      step(); check_eq("ra_after", bus.pc, 32'h0000_3000);
      check_eq("ra_red_after", 32'(bus.redirect), 32'h0);

      // Wrap at top of address space; reserved jmp_req acts as none
      bus.jmp_req = 2'b10; bus.jr_addr = 32'hFFFF_FFFC;
      step(); check_eq("wr_pc", bus.pc, 32'hFFFF_FFFC);
      check_eq("wr_plus4", bus.pc_plus4, 32'h0000_0000);
      idle(); bus.jmp_req = 2'b11; bus.pc_step = 1'b1;
      step(); check_eq("wr_step", bus.pc, 32'h0000_0000);
      check_eq("wr_red", 32'(bus.redirect), 32'h0);

      // Negative offset below zero wraps: 4 - 8 = 0xFFFF_FFFC
      idle(); bus.br_req = 1'b1; bus.imm16 = 16'hFFFE;
      step(); idle(); bus.br_taken = 1'b1;
      step(); check_eq("neg_pc", bus.pc, 32'hFFFF_FFFC);
      check_eq("neg_red", 32'(bus.redirect), 32'h1);
      bus.br_taken = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
